// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: load/value/sign in, segment/enable/status out.
// The blink signal exists only when SEG7_BLINK_EN is defined.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  neg;
`ifdef SEG7_BLINK_EN
  logic                  blink;
`endif
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  err;
  logic                  ovf;

`ifdef SEG7_BLINK_EN
  modport master (output load, bcd_in, neg, blink, input seg, an, err, ovf);
  modport slave  (input load, bcd_in, neg, blink, output seg, an, err, ovf);
`else
  modport master (output load, bcd_in, neg, input seg, an, err, ovf);
  modport slave  (input load, bcd_in, neg, output seg, an, err, ovf);
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed BCD to seven-segment driver with leading-zero blanking, minus sign
// and invalid-nibble flag. Optional display flashing is built when SEG7_BLINK_EN is defined.
module seg7_scan_driver #(
  parameter int DIGITS       = 2,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input logic              clk,
  input logic              rst,
  seg7_scan_driver_if.slave bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_ERR   = 7'b0110000;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_ERR;
    endcase
    return s;
  endfunction

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     val_q, val_d;
  logic              sgn_q, sgn_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  int unsigned       msd;
  int unsigned       idx_u;
  logic [3:0]        digit;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    val_d = bus.load ? bus.bcd_in : val_q;
    sgn_d = bus.load ? bus.neg : sgn_q;
  end

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_q, frame_d;
  logic          phase_q, phase_d;

  always_comb begin
    frame_d = frame_q;
    phase_d = phase_q;
    if ((cnt_q == CNT_LAST) && (idx_q == IDX_LAST)) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      phase_q <= phase_d;
    end
  end
`endif

  // Outputs decode the current (idx_q, val_q) pair, so a load landing on an
  // idx advance is seen together with the new idx one edge later.
  always_comb begin
    msd   = 0;
    err_d = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (val_q[4*i +: 4] != 4'd0) msd = i;
      if (val_q[4*i +: 4] > 4'd9)  err_d = 1'b1;
    end
    idx_u = 32'(idx_q);
    digit = val_q[4*idx_u +: 4];
    ovf_d = sgn_q && (msd == unsigned'(DIGITS - 1));
    if (idx_u > msd)
      seg_d = (sgn_q && (idx_u == msd + 1)) ? SEG_MINUS : SEG_BLANK;
    else
      seg_d = bcd_to_seg(digit);
    an_d = ~(DIGITS'(1) << idx_q);
`ifdef SEG7_BLINK_EN
    if (bus.blink && phase_q) begin
      seg_d = SEG_BLANK;
      an_d  = '1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      val_q <= '0;
      sgn_q <= 1'b0;
      seg_q <= SEG_BLANK;
      an_q  <= '1;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      val_q <= val_d;
      sgn_q <= sgn_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.err = err_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
// Blink scenario is compiled only when SEG7_BLINK_EN is defined.
module tb_seg7_scan_driver;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   pass  = 0;

  seg7_scan_driver_if #(.DIGITS(4)) bus_if ();

  seg7_scan_driver #(
    .DIGITS      (4),
    .SCAN_DIV    (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Captures on the first edge, returns just after the edge where the value is visible.
  task automatic do_load(input logic [15:0] v, input logic n);
    bus_if.bcd_in = v;
    bus_if.neg    = n;
    bus_if.load   = 1'b1;
    tick();
    bus_if.load   = 1'b0;
    tick();
  endtask

  task automatic wait_digit(input int k);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << k);
    n = 0;
    while (bus_if.an !== want && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (n >= 40) $display("FAIL wait_digit%0d an=%b expected=%b (timeout)", k, bus_if.an, want);
    else pass++;
  endtask

  task automatic test_reset();
    logic [3:0] an_seq [5];
    int         gap    [5];
    an_seq = '{4'b1110, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    gap    = '{1, 3, 1, 4, 4};
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus_if.seg !== 7'b1111111) $display("FAIL reset_seg seg=%b expected=1111111", bus_if.seg); else pass++;
    total++; if (bus_if.an  !== 4'b1111)    $display("FAIL reset_an an=%b expected=1111", bus_if.an); else pass++;
    total++; if (bus_if.err !== 1'b0)       $display("FAIL reset_err err=%b expected=0", bus_if.err); else pass++;
    total++; if (bus_if.ovf !== 1'b0)       $display("FAIL reset_ovf ovf=%b expected=0", bus_if.ovf); else pass++;
    rst = 1'b0;
    tick();
    total++; if (bus_if.seg !== 7'b0000001) $display("FAIL first_edge_seg seg=%b expected=0000001", bus_if.seg); else pass++;
    // Edges 1,4,5,9,13 after release; then one full frame later back to digit 0.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) repeat (gap[i]) tick();
      total++;
      if (bus_if.an !== an_seq[i]) $display("FAIL scan_an_%0d an=%b expected=%b", i, bus_if.an, an_seq[i]);
      else pass++;
      if (i >= 2) begin
        total++;
        if (bus_if.seg !== 7'b1111111) $display("FAIL lz_blank_%0d seg=%b expected=1111111", i, bus_if.seg);
        else pass++;
      end
    end
    repeat (4) tick();
    total++; if (bus_if.an !== 4'b1110) $display("FAIL scan_wrap an=%b expected=1110", bus_if.an); else pass++;
  endtask

  task automatic test_decode();
    logic [15:0] vals [4];
    logic [6:0]  exp_seg [4][4];
    vals = '{16'h0905, 16'h8765, 16'h4321, 16'h0090};
    exp_seg = '{
      '{7'b0100100, 7'b0000001, 7'b0000100, 7'b1111111},
      '{7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000},
      '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100},
      '{7'b0000001, 7'b0000100, 7'b1111111, 7'b1111111}};
    for (int v = 0; v < 4; v++) begin
      do_load(vals[v], 1'b0);
      total++; if (bus_if.err !== 1'b0) $display("FAIL decode_err val=%h err=%b expected=0", vals[v], bus_if.err); else pass++;
      total++; if (bus_if.ovf !== 1'b0) $display("FAIL decode_ovf val=%h ovf=%b expected=0", vals[v], bus_if.ovf); else pass++;
      for (int k = 0; k < 4; k++) begin
        wait_digit(k);
        total++;
        if (bus_if.seg !== exp_seg[v][k])
          $display("FAIL decode val=%h digit%0d seg=%b expected=%b", vals[v], k, bus_if.seg, exp_seg[v][k]);
        else pass++;
      end
    end
  endtask

  task automatic test_sign();
    logic [6:0] e42 [4];
    e42 = '{7'b0010010, 7'b1001100, 7'b1111110, 7'b1111111};
    do_load(16'h0042, 1'b1);
    total++; if (bus_if.ovf !== 1'b0) $display("FAIL sign_ovf_0042 ovf=%b expected=0", bus_if.ovf); else pass++;
    for (int k = 0; k < 4; k++) begin
      wait_digit(k);
      total++;
      if (bus_if.seg !== e42[k]) $display("FAIL sign_0042 digit%0d seg=%b expected=%b", k, bus_if.seg, e42[k]);
      else pass++;
    end
    do_load(16'h1042, 1'b1);
    total++; if (bus_if.ovf !== 1'b1) $display("FAIL sign_ovf_1042 ovf=%b expected=1", bus_if.ovf); else pass++;
    wait_digit(2);
    total++; if (bus_if.seg !== 7'b0000001) $display("FAIL inner_zero seg=%b expected=0000001", bus_if.seg); else pass++;
    wait_digit(3);
    total++; if (bus_if.seg !== 7'b1001111) $display("FAIL no_minus seg=%b expected=1001111", bus_if.seg); else pass++;
    do_load(16'h0000, 1'b1);
    total++; if (bus_if.ovf !== 1'b0) $display("FAIL ovf_not_sticky ovf=%b expected=0", bus_if.ovf); else pass++;
    wait_digit(0);
    total++; if (bus_if.seg !== 7'b0000001) $display("FAIL neg_zero_d0 seg=%b expected=0000001", bus_if.seg); else pass++;
    wait_digit(1);
    total++; if (bus_if.seg !== 7'b1111110) $display("FAIL neg_zero_d1 seg=%b expected=1111110", bus_if.seg); else pass++;
    do_load(16'h0000, 1'b0);
  endtask

  task automatic test_err();
    bus_if.bcd_in = 16'h00A3;
    bus_if.neg    = 1'b0;
    bus_if.load   = 1'b1;
    tick();
    bus_if.load   = 1'b0;
    total++; if (bus_if.err !== 1'b0) $display("FAIL err_latency_n err=%b expected=0", bus_if.err); else pass++;
    tick();
    total++; if (bus_if.err !== 1'b1) $display("FAIL err_00A3 err=%b expected=1", bus_if.err); else pass++;
    wait_digit(0);
    total++; if (bus_if.seg !== 7'b0000110) $display("FAIL err_d0 seg=%b expected=0000110", bus_if.seg); else pass++;
    wait_digit(1);
    total++; if (bus_if.seg !== 7'b0110000) $display("FAIL err_d1 seg=%b expected=0110000", bus_if.seg); else pass++;
    do_load(16'h0003, 1'b0);
    total++; if (bus_if.err !== 1'b0) $display("FAIL err_cleared err=%b expected=0", bus_if.err); else pass++;
    wait_digit(1);
    total++; if (bus_if.seg !== 7'b1111111) $display("FAIL err_cleared_d1 seg=%b expected=1111111", bus_if.seg); else pass++;
    do_load(16'hF000, 1'b0);
    total++; if (bus_if.err !== 1'b1) $display("FAIL err_F000 err=%b expected=1", bus_if.err); else pass++;
    wait_digit(2);
    total++; if (bus_if.seg !== 7'b0000001) $display("FAIL err_msd_d2 seg=%b expected=0000001", bus_if.seg); else pass++;
    wait_digit(3);
    total++; if (bus_if.seg !== 7'b0110000) $display("FAIL err_F000_d3 seg=%b expected=0110000", bus_if.seg); else pass++;
  endtask

  task automatic test_load_at_wrap();
    do_load(16'h0905, 1'b0);
    wait_digit(2);
    wait_digit(3);
    // idx reached 3 one edge ago; its wrap edge is three edges from now.
    tick();
    tick();
    bus_if.bcd_in = 16'h0007;
    bus_if.neg    = 1'b0;
    bus_if.load   = 1'b1;
    tick();
    bus_if.load   = 1'b0;
    total++; if (bus_if.an !== 4'b0111) $display("FAIL wrap_pre_an an=%b expected=0111", bus_if.an); else pass++;
    tick();
    total++; if (bus_if.an !== 4'b1110) $display("FAIL wrap_an an=%b expected=1110", bus_if.an); else pass++;
    total++; if (bus_if.seg !== 7'b0001111) $display("FAIL wrap_new_seg seg=%b expected=0001111", bus_if.seg); else pass++;
  endtask

  task automatic test_rst_with_load();
    bus_if.bcd_in = 16'h1234;
    bus_if.neg    = 1'b1;
    bus_if.load   = 1'b1;
    rst = 1'b1;
    tick();
    bus_if.load = 1'b0;
    bus_if.neg  = 1'b0;
    total++; if (bus_if.seg !== 7'b1111111) $display("FAIL rstload_seg seg=%b expected=1111111", bus_if.seg); else pass++;
    total++; if (bus_if.an !== 4'b1111) $display("FAIL rstload_an an=%b expected=1111", bus_if.an); else pass++;
    total++; if (bus_if.ovf !== 1'b0) $display("FAIL rstload_ovf ovf=%b expected=0", bus_if.ovf); else pass++;
    rst = 1'b0;
    tick();
    total++; if (bus_if.an !== 4'b1110) $display("FAIL rstload_an1 an=%b expected=1110", bus_if.an); else pass++;
    total++; if (bus_if.seg !== 7'b0000001) $display("FAIL rstload_val seg=%b expected=0000001", bus_if.seg); else pass++;
    wait_digit(1);
    total++; if (bus_if.seg !== 7'b1111111) $display("FAIL rstload_sgn seg=%b expected=1111111", bus_if.seg); else pass++;
  endtask

`ifdef SEG7_BLINK_EN
  task automatic test_blink();
    bus_if.blink = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (32) tick();
    total++; if (bus_if.an !== 4'b0111) $display("FAIL blink_e32 an=%b expected=0111", bus_if.an); else pass++;
    tick();
    total++; if (bus_if.an !== 4'b1111) $display("FAIL blink_e33 an=%b expected=1111", bus_if.an); else pass++;
    total++; if (bus_if.seg !== 7'b1111111) $display("FAIL blink_e33_seg seg=%b expected=1111111", bus_if.seg); else pass++;
    repeat (15) tick();
    total++; if (bus_if.an !== 4'b1111) $display("FAIL blink_e48 an=%b expected=1111", bus_if.an); else pass++;
    repeat (16) tick();
    total++; if (bus_if.an !== 4'b1111) $display("FAIL blink_e64 an=%b expected=1111", bus_if.an); else pass++;
    tick();
    total++; if (bus_if.an !== 4'b1110) $display("FAIL blink_e65 an=%b expected=1110", bus_if.an); else pass++;
    repeat (35) tick();
    total++; if (bus_if.an !== 4'b1111) $display("FAIL blink_e100 an=%b expected=1111", bus_if.an); else pass++;
    bus_if.blink = 1'b0;
    tick();
    total++; if (bus_if.an !== 4'b1101) $display("FAIL blink_drop an=%b expected=1101", bus_if.an); else pass++;
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus_if.load   = 1'b0;
    bus_if.bcd_in = '0;
    bus_if.neg    = 1'b0;
`ifdef SEG7_BLINK_EN
    bus_if.blink  = 1'b0;
`endif
    test_reset();
    test_decode();
    test_sign();
    test_err();
    test_load_at_wrap();
    test_rst_with_load();
`ifdef SEG7_BLINK_EN
    test_blink();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed BCD-to-seven-segment display driver. It latches a packed DIGITS-digit BCD value plus a sign flag and scans the digits onto a shared active-low segment bus with one-hot active-low digit enables. It supports leading-zero blanking, a minus sign and flagging of invalid nibbles. It replaces per-digit static decoders on the display board and sits between the counter/remote-control datapath and the physical display pins.

## Interface
- DIGITS, 2: number of digits scanned, 1..8.
- SCAN_DIV, 50000: clock cycles each digit is driven (dwell), ≥1.
- BLINK_FRAMES, 64: full scan frames per blink phase (used only with SEG7_BLINK_EN), ≥1.

- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- load  in  1  one-cycle strobe: capture bcd_in and neg.
- bcd_in  in  4*DIGITS  packed BCD; nibble k = digit k, digit 0 = least significant, in bits [3:0].
- neg  in  1  sign captured with load; 1 = display minus.
- blink  in  1  present only with SEG7_BLINK_EN; 1 = flash display.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low, registered.
- an  out  DIGITS  digit enables, active-low one-hot, registered.
- err  out  1  high while the latched value holds any nibble > 9, registered.
- ovf  out  1  high while neg is latched and no digit is free for the minus sign, registered.

## Operation
- The display register (val, sgn) is loaded on load=1 and otherwise holds its value. Reset clears it to all zero and sgn=0.
- Scan: prescaler cnt counts 0..SCAN_DIV-1. At cnt=SCAN_DIV-1 it wraps to 0 and the digit index idx advances modulo DIGITS (DIGITS-1 → 0).
- Decode per nibble, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Any value 10..15 shows "E" = 0110000.
- Leading-zero blanking:
  - msd = highest index whose nibble is nonzero. Invalid nibbles count as nonzero. msd = 0 if all nibbles are zero.
  - Digits above msd show blank = 1111111.
  - Digit 0 is never blanked.
- Sign:
  - If sgn=1 and msd < DIGITS-1, digit msd+1 shows minus = 1111110.
  - If sgn=1 and msd = DIGITS-1, no minus is shown and ovf=1.
  - ovf is combinationally derived from the latched state and then registered.
- Exactly one an bit is low at any time after the first post-reset edge, except during blink off-phase.
- err and ovf reflect the latched value; they are not sticky across loads.

## Timing
- Reset values while rst=1 and on the edge it is sampled:
  - seg=1111111, an=all ones, err=0, ovf=0.
  - cnt=0, idx=0, val=0, sgn=0.
- Outputs are registered from the current idx/val. The first edge after rst falls drives an=~(1<<0) and seg=0000001.
- Digit dwell is SCAN_DIV cycles; a frame is DIGITS*SCAN_DIV cycles. With SCAN_DIV=1, idx advances every cycle.
- Load latency: a value loaded on edge N appears on seg/err/ovf at edge N+1. Scan position (cnt, idx) is unaffected by load.
- load coincident with an idx advance: the new idx is decoded using the new val at the next edge, with no mixed-value cycle.
- rst concurrent with load: rst wins and val is cleared.
- rst asserted mid-scan: state returns to reset values on that edge. No partial digit is completed.

## Configuration
- SEG7_BLINK_EN defined:
  - The blink port exists.
  - A frame counter toggles phase every BLINK_FRAMES complete frames (at idx wrap DIGITS-1 → 0). Phase is cleared by reset.
  - While blink=1 and phase=1: an=all ones and seg=1111111. The scan continues.
  - blink=0 forces normal display from the next edge; phase keeps counting.
- SEG7_BLINK_EN undefined: no blink port, no frame counter, and the display is never forced off.

## Test plan
- Reset/idle, DIGITS=4, SCAN_DIV=4: release rst.
  - Edge 1: an=1110, seg=0000001.
  - idx advances every 4 cycles. Digits 1..3 show 1111111 (leading zeros blanked).
- Load 0x0905, neg=0: digits 0..3 = 0100100, 0000001, 0000100, 1111111. err=0.
- Load 0x0042, neg=1:
  - digit 2 = 1111110, digit 3 = 1111111, ovf=0.
  - Then load 0x1042, neg=1: no minus, ovf=1 on the next edge.
- Load 0x00A3: digit 1 = 0110000, err=1. Then load 0x0003: err=0 one cycle later.
- Load strobed on the cycle idx wraps 3→0, and separately rst asserted with load high:
  - The first case decodes the new value with no stale cycle.
  - The second case leaves val=0 and outputs at reset values.
- SEG7_BLINK_EN, BLINK_FRAMES=2, blink=1: an=1111 for frames 2-3, scanning resumes in frames 4-5. Dropping blink restores display on the next edge.
